// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 message scheduler: block geometry,
// padding constants, FSM state encoding and the length-field byte picker.
package sha_pkg;

  localparam int BLOCK_BYTES    = 64;
  localparam int LEN_BYTES      = 8;
  localparam int DIGEST_NIBBLES = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam int BUF_ADDR_W = $clog2(BLOCK_BYTES);
  localparam int NIB_CNT_W  = $clog2(DIGEST_NIBBLES);

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    WAIT_CORE,
    ARM,
    BURST,
    GAP,
    WAIT_DIG,
    COLLECT,
    DONE
  } state_t;

  // Byte idx (0 = most significant) of the 64-bit big-endian bit length.
  function automatic logic [7:0] len_byte(input logic [63:0] bit_len,
                                          input logic [2:0]  idx);
    logic [5:0] shift;
    shift = {3'd7 - idx, 3'b000};
    return bit_len[shift +: 8];
  endfunction

endpackage

// File: rtl/sha_block_buf.sv
// 64x8 block buffer: one write port and one read port, each walking its own
// auto-incrementing pointer; reads are registered (data one cycle after rd_en).
module sha_block_buf
  import sha_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data
);

  logic [7:0]            mem [BLOCK_BYTES];
  logic [BUF_ADDR_W-1:0] wr_ptr;
  logic [BUF_ADDR_W-1:0] rd_ptr;

  // Storage write; every location is rewritten by FILL before it is read.
  // NOTE: the memory array has no reset -- clearing 64 bytes buys nothing
  // because no byte is read before FILL has written it, and a reset on the
  // array would stop it mapping onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at 64, so each FILL and each BURST starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/sha_msg_sched.sv
// SHA-256 message scheduler: pads the incoming byte stream into 64-byte
// blocks, bursts each block contiguously to the core, then assembles the
// digest from the core's nibble stream.
module sha_msg_sched
  import sha_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       core_data,
  output logic             core_write_enable,
  output logic             core_first_block,
  output logic             core_last_block,
  input  logic             core_busy,
  input  logic [3:0]       core_digest,
  input  logic             core_output_valid,
  output logic [255:0]     digest,
  output logic             done,
  output logic             busy
);

  // One extra bit so the stream position can run past msg_len into the
  // padding without wrapping, even for msg_len = 2^LEN_W-1.
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [BUF_ADDR_W-1:0] LAST_BYTE = BUF_ADDR_W'(BLOCK_BYTES - 1);
  localparam logic [BUF_ADDR_W-1:0] LEN_START = BUF_ADDR_W'(BLOCK_BYTES - LEN_BYTES);
  localparam logic [NIB_CNT_W-1:0]  LAST_NIB  = NIB_CNT_W'(DIGEST_NIBBLES - 1);

  state_t state, state_nxt;

  logic [LEN_W-1:0]      len_q;
  logic [CNT_W-1:0]      n_blocks_q;
  logic [CNT_W-1:0]      blk_q;
  logic [CNT_W-1:0]      pos_q;      // byte position in the padded stream
  logic [BUF_ADDR_W-1:0] burst_cnt;
  logic [NIB_CNT_W-1:0]  nib_cnt;
  logic [251:0]          nib_sr;     // the 63 nibbles preceding the final one

  logic       start_ok;
  logic       msg_left;
  logic       last_blk;
  logic [7:0] fill_byte;
  logic       buf_wr_en;
  logic       buf_rd_en;
  logic       nib_take;
  logic       last_nib;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign msg_left = pos_q < {1'b0, len_q};
  assign last_blk = (blk_q + CNT_ONE) == n_blocks_q;

  // State register.
  // NOTE: every clocked block uses <= so all flops update from the same
  // pre-edge values; a blocking = here would let later statements see
  // the new value and silently change the circuit.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment first means no path leaves state_nxt
  // unassigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_ok) state_nxt = FILL;
      FILL:       if (buf_wr_en && pos_q[BUF_ADDR_W-1:0] == LAST_BYTE) state_nxt = WAIT_CORE;
      WAIT_CORE:  if (!core_busy) state_nxt = (blk_q == '0) ? ARM : BURST;
      ARM:        state_nxt = BURST;
      BURST:      if (burst_cnt == LAST_BYTE) state_nxt = GAP;
      GAP:        state_nxt = last_blk ? WAIT_DIG : FILL;
      WAIT_DIG:   if (nib_take) state_nxt = COLLECT;
      COLLECT:    if (last_nib) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State-decoded controls: input handshake, buffer strobes, nibble capture.
  always_comb begin
    in_ready  = (state == FILL) && msg_left;
    buf_wr_en = (state == FILL) && (!msg_left || in_valid);
    buf_rd_en = (state == BURST);
    busy      = (state != IDLE) && (state != DONE);
    nib_take  = core_output_valid && (state == WAIT_DIG || state == COLLECT);
    last_nib  = core_output_valid && (state == COLLECT) && (nib_cnt == LAST_NIB);
  end

  // Byte written into the buffer: message, then 0x80, zeros, bit length.
  always_comb begin
    fill_byte = 8'h00;
    if (msg_left)
      fill_byte = in_data;
    else if (pos_q == {1'b0, len_q})
      fill_byte = PAD_BYTE;
    else if (last_blk && pos_q[BUF_ADDR_W-1:0] >= LEN_START)
      fill_byte = len_byte(64'(len_q) << 3, pos_q[2:0]);
  end

  // Hash bookkeeping: length, block count, stream position, digest capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      n_blocks_q <= '0;
      blk_q      <= '0;
      pos_q      <= '0;
      burst_cnt  <= '0;
      nib_cnt    <= '0;
      nib_sr     <= '0;
      digest     <= '0;
      done       <= 1'b0;
    end else begin
      done <= last_nib;
      if (start_ok) begin
        len_q      <= msg_len;
        n_blocks_q <= (({1'b0, msg_len} + CNT_W'(LEN_BYTES)) >> BUF_ADDR_W) + CNT_ONE;
        blk_q      <= '0;
        pos_q      <= '0;
        nib_cnt    <= '0;
        nib_sr     <= '0;
      end
      if (buf_wr_en)        pos_q     <= pos_q + CNT_ONE;
      if (state == BURST)   burst_cnt <= burst_cnt + 1'b1;
      if (state == GAP)     blk_q     <= blk_q + CNT_ONE;
      if (nib_take) begin
        nib_sr  <= {nib_sr[247:0], core_digest};
        nib_cnt <= nib_cnt + 1'b1;
      end
      if (last_nib) digest <= {nib_sr, core_digest};
    end
  end

  // Registered core strobes, aligned with the buffer's registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_write_enable <= 1'b0;
      core_first_block  <= 1'b0;
      core_last_block   <= 1'b0;
    end else begin
      core_write_enable <= (state == BURST);
      core_first_block  <= (state == ARM) ||
                           (state == BURST && burst_cnt == '0 && blk_q == '0);
      core_last_block   <= (state == BURST && burst_cnt == '0 && last_blk);
    end
  end

  sha_block_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr_en),
    .wr_data (fill_byte),
    .rd_en   (buf_rd_en),
    .rd_data (core_data)
  );

endmodule

// File: tb/tb_sha_msg_sched.sv
// Self-checking bench for sha_msg_sched: drives messages, plays the SHA core,
// and compares the padded block stream and assembled digest with a model.
module tb_sha_msg_sched;

  localparam int LEN_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       core_data;
  logic             core_write_enable;
  logic             core_first_block;
  logic             core_last_block;
  logic             core_busy = 1'b0;
  logic [3:0]       core_digest = '0;
  logic             core_output_valid = 1'b0;
  logic [255:0]     digest;
  logic             done;
  logic             busy;

  sha_msg_sched #(.LEN_W(LEN_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .msg_len           (msg_len),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .core_data         (core_data),
    .core_write_enable (core_write_enable),
    .core_first_block  (core_first_block),
    .core_last_block   (core_last_block),
    .core_busy         (core_busy),
    .core_digest       (core_digest),
    .core_output_valid (core_output_valid),
    .digest            (digest),
    .done              (done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc++;

  // Message bytes for the current hash.
  logic [7:0] msg[$];

  // Observations of the core-side interface.
  bit         mon_en = 1'b0;
  logic [7:0] got_data[$];
  bit         got_first[$];
  bit         got_last[$];
  int         runs[$];
  int         gaps[$];
  int         run_len, gap_len, arm_cnt, arm_bad, stray_last, busy_writes;
  int         done_cnt, first_cyc;
  logic [255:0] done_digest;

  always @(negedge clk) begin
    if (mon_en) begin
      if (core_write_enable) begin
        if (got_data.size() == 0) first_cyc = cyc;
        if (gap_len > 0 && runs.size() > 0) gaps.push_back(gap_len);
        gap_len = 0;
        got_data.push_back(core_data);
        got_first.push_back(core_first_block);
        got_last.push_back(core_last_block);
        run_len++;
        if (core_busy) busy_writes++;
      end else begin
        if (run_len > 0) begin
          runs.push_back(run_len);
          run_len = 0;
        end
        if (runs.size() > 0) gap_len++;
        if (core_first_block) begin
          arm_cnt++;
          if (got_data.size() != 0) arm_bad++;
        end
        if (core_last_block) stray_last++;
      end
      if (done) begin
        done_cnt++;
        done_digest = digest;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    got_data.delete(); got_first.delete(); got_last.delete();
    runs.delete(); gaps.delete();
    run_len = 0; gap_len = 0; arm_cnt = 0; arm_bad = 0; stray_last = 0;
    busy_writes = 0; done_cnt = 0; first_cyc = 0; done_digest = '0;
  endtask

  // Source: pattern 0 continuous, 1 valid every other cycle, 2 random bubbles.
  task automatic feed(input int len, input int pattern);
    int idx = 0;
    int c = 0;
    bit v, hs;
    while (idx < len && c < 4000) begin
      v = (pattern == 0) ? 1'b1 : (pattern == 1) ? (c % 2 == 0) : ($urandom % 3 != 0);
      in_valid = v;
      in_data  = v ? msg[idx] : 8'($urandom);
      hs = in_valid && in_ready;
      step();
      if (hs) idx++;
      c++;
    end
    checks++;
    if (idx != len) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d bytes, required %0d", idx, len);
    end
    // Keep offering junk while padding is generated: it must not be taken.
    in_valid = (pattern == 2);
    in_data  = 8'hEE;
  endtask

  // Core model: a stray digest strobe early, then the digest once all blocks arrived.
  task automatic core_model(input int n, input logic [255:0] dig);
    int k = 0;
    int w = 0;
    bit v;
    core_output_valid = 1'b1;
    core_digest = 4'($urandom);
    step();
    core_output_valid = 1'b0;
    while (got_data.size() < n * 64 && w < 6000) begin
      step();
      w++;
    end
    checks++;
    if (got_data.size() < n * 64) begin
      errors++;
      $display("FAIL stream_timeout: got %0d bytes, required %0d", got_data.size(), n * 64);
    end
    repeat ($urandom % 4) step();
    while (k < 64) begin
      v = ($urandom % 4 != 0);
      core_output_valid = v;
      core_digest = v ? dig[255 - 4 * k -: 4] : 4'($urandom);
      step();
      if (v) k++;
    end
    core_output_valid = 1'b0;
  endtask

  // Holds core_busy after the first block and pokes start mid-hash.
  task automatic busy_ctl(input int hold);
    if (hold > 0) begin
      for (int i = 0; i < 3000 && runs.size() < 1; i++) step();
      core_busy = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (i == hold / 2) begin
          start = 1'b1;
          msg_len = 5;
          step();
          start = 1'b0;
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_busy: busy=%b required 1", busy);
          end
        end else begin
          step();
        end
      end
      core_busy = 1'b0;
    end
  endtask

  task automatic run_hash(input int len, input int pattern, input logic [255:0] dig,
                          input int hold, input string name);
    int n = (len + 8) / 64 + 1;
    logic [7:0] exp[$];
    logic [63:0] bl;
    int bad_runs = 0;
    int lat;

    for (int i = 0; i < len; i++) exp.push_back(msg[i]);
    exp.push_back(8'h80);
    while (exp.size() % 64 != 56) exp.push_back(8'h00);
    bl = 64'(len) * 64'd8;
    for (int b = 7; b >= 0; b--) exp.push_back(bl[8 * b +: 8]);

    mon_clear();
    mon_en = 1'b1;
    start = 1'b1;
    msg_len = LEN_W'(len);
    start_cyc = cyc;
    step();
    start = 1'b0;
    msg_len = $urandom;
    fork
      feed(len, pattern);
      core_model(n, dig);
      busy_ctl(hold);
    join
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    repeat (3) step();
    in_valid = 1'b0;

    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulse: %0d cycles high, required 1", name, done_cnt);
    end
    checks++;
    if (done_digest !== dig) begin
      errors++;
      $display("FAIL %s digest: got %h required %h", name, done_digest, dig);
    end
    checks++;
    if (digest !== dig || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s hold_after_done: digest %h busy %b, required %h busy 0", name, digest, busy, dig);
    end
    checks++;
    if (got_data.size() != exp.size()) begin
      errors++;
      $display("FAIL %s stream_len: got %0d required %0d", name, got_data.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp[i] || got_first[i] !== (i == 0) || got_last[i] !== (i == (n - 1) * 64)) begin
        errors++;
        $display("FAIL %s byte[%0d]: got %h first %b last %b, required %h first %b last %b",
                 name, i, got_data[i], got_first[i], got_last[i], exp[i], (i == 0), (i == (n - 1) * 64));
      end
    end
    foreach (runs[i]) if (runs[i] != 64) bad_runs++;
    checks++;
    if (runs.size() != n || bad_runs != 0) begin
      errors++;
      $display("FAIL %s bursts: %0d bursts (%0d not 64 long), required %0d of 64", name, runs.size(), bad_runs, n);
    end
    checks++;
    if (arm_cnt != 1 || arm_bad != 0 || stray_last != 0) begin
      errors++;
      $display("FAIL %s arm: arm cycles %0d late %0d stray last %0d, required 1 0 0", name, arm_cnt, arm_bad, stray_last);
    end
    checks++;
    if (busy_writes != 0) begin
      errors++;
      $display("FAIL %s write_while_busy: %0d writes, required 0", name, busy_writes);
    end
    lat = first_cyc - start_cyc - 1;
    checks++;
    if (lat < 66 || (pattern == 0 && hold == 0 && lat > 68)) begin
      errors++;
      $display("FAIL %s latency: %0d cycles, required at least 66", name, lat);
    end
    if (hold > 0) begin
      checks++;
      if (gaps.size() < 1 || gaps[0] < hold) begin
        errors++;
        $display("FAIL %s busy_stall: gap %0d cycles, required at least %0d", name, (gaps.size() > 0) ? gaps[0] : 0, hold);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({core_write_enable, core_first_block, core_last_block, in_ready, done, busy} !== 6'b0 ||
        core_data !== 8'h00 || digest !== 256'h0) begin
      errors++;
      $display("FAIL %s: we %b first %b last %b ready %b done %b busy %b data %h digest %h, required all 0",
               name, core_write_enable, core_first_block, core_last_block, in_ready, done, busy, core_data, digest);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset_state");
    reset = 1'b0;
    step();
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_len56();
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'h30);
    run_hash(56, 0, 256'hbd03ac1428f0ea86f4b83a731ffc7967bb82866d8545322f888d2f6e857ffc18, 0, "len56");
    checks++;
    if (got_data.size() != 128 || got_data[56] !== 8'h80 || got_data[63] !== 8'h00 ||
        got_data[126] !== 8'h01 || got_data[127] !== 8'hC0 || got_last[64] !== 1'b1) begin
      errors++;
      $display("FAIL len56_markers: size %0d b56 %h b63 %h b126 %h b127 %h",
               got_data.size(), got_data[56], got_data[63], got_data[126], got_data[127]);
    end
  endtask

  task automatic test_empty();
    msg.delete();
    run_hash(0, 0, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 0, "empty");
    checks++;
    if (got_data.size() != 64 || got_data[0] !== 8'h80 || got_first[0] !== 1'b1 ||
        got_last[0] !== 1'b1 || got_data[63] !== 8'h00) begin
      errors++;
      $display("FAIL empty_block: size %0d b0 %h first %b last %b, required 64 80 1 1",
               got_data.size(), got_data[0], got_first[0], got_last[0]);
    end
  endtask

  task automatic test_abc_bubbles();
    msg = '{8'h61, 8'h62, 8'h63};
    run_hash(3, 1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0, "abc_bubbles");
  endtask

  task automatic test_core_busy();
    msg.delete();
    for (int i = 0; i < 100; i++) msg.push_back(8'($urandom));
    run_hash(100, 2, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             80, "core_busy");
  endtask

  task automatic test_reset_mid_burst();
    int w = 0;
    mon_clear();
    mon_en = 1'b1;
    start = 1'b1;
    msg_len = 56;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h30;
    while (got_data.size() < 20 && w < 400) begin
      step();
      w++;
    end
    checks++;
    if (got_data.size() < 20) begin
      errors++;
      $display("FAIL reset_mid_burst_reach: got %0d bytes, required 20", got_data.size());
    end
    reset = 1'b1;
    step();
    check_idle_outputs("reset_mid_burst");
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    mon_en = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    run_hash(3, 0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0, "after_reset");
  endtask

  task automatic test_random();
    int lens[8] = '{1, 55, 63, 64, 119, 120, 0, 0};
    lens[6] = $urandom_range(0, 200);
    lens[7] = $urandom_range(0, 200);
    foreach (lens[t]) begin
      msg.delete();
      for (int i = 0; i < lens[t]; i++) msg.push_back(8'($urandom));
      run_hash(lens[t], 2, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               0, $sformatf("random_len%0d", lens[t]));
    end
  endtask

  initial begin
    test_reset();
    test_len56();
    test_empty();
    test_abc_bubbles();
    test_core_busy();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
